// File: rtl/i2c_target_responder_if.sv
// I2C target responder bus bundle: pins, rx stream, tx holding handshake
// and event pulses.
interface i2c_target_responder_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underflow;
    logic       start_det;
    logic       stop_det;
    logic       nack_seen;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, tx_data, tx_valid,
        output sda_o, rx_data, rx_valid, rx_first, tx_ready,
        output tx_underflow, start_det, stop_det, nack_seen, busy
    );

    modport master (
        output scl_i, sda_i, tx_data, tx_valid,
        input  sda_o, rx_data, rx_valid, rx_first, tx_ready,
        input  tx_underflow, start_det, stop_det, nack_seen, busy
    );
endinterface

// File: rtl/i2c_target_responder.sv
// Single-address I2C target: synchronized SCL/SDA, open-drain SDA,
// write bytes streamed as rx pulses, read bytes from a one-entry tx hold.
module i2c_target_responder #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h22,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_target_responder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_q, sda_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]             shreg, hold_data, next_byte;
    logic [2:0]             cnt;
    logic                   hold_full, slot, rw, first, load_now;
    logic                   sda_r, busy_r, rx_valid_r, rx_first_r;
    logic                   uflow_r, start_r, stop_r, nack_r;
    logic [7:0]             rx_data_r;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_c   = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_c    = scl_s & scl_q & ~sda_q & sda_s;
    assign next_byte = hold_full ? hold_data : TX_IDLE_BYTE;
    // Shift register reload point: end of address ACK (read) or master ACK
    assign load_now  = scl_fall & ~start_c & ~stop_c & slot &
                       ((state == ADDR_ACK & rw) | (state == READ_ACK));

    assign bus.sda_o        = sda_r;
    assign bus.busy         = busy_r;
    assign bus.rx_data      = rx_data_r;
    assign bus.rx_valid     = rx_valid_r;
    assign bus.rx_first     = rx_first_r;
    assign bus.tx_ready     = ~hold_full;
    assign bus.tx_underflow = uflow_r;
    assign bus.start_det    = start_r;
    assign bus.stop_det     = stop_r;
    assign bus.nack_seen    = nack_r;

    // Synchronize the bus pins and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    // One-entry tx holding register; a new byte wins over a same-cycle empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else begin
            if (load_now)
                hold_full <= 1'b0;
            if (bus.tx_valid && !hold_full) begin
                hold_data <= bus.tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    // Protocol FSM; START/STOP override bit processing in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= 8'h00;
            cnt        <= 3'd7;
            slot       <= 1'b0;
            rw         <= 1'b0;
            first      <= 1'b0;
            sda_r      <= 1'b1;
            busy_r     <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_first_r <= 1'b0;
            uflow_r    <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            nack_r     <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_first_r <= 1'b0;
            uflow_r    <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            nack_r     <= 1'b0;
            if (start_c) begin
                state   <= ADDR;
                cnt     <= 3'd7;
                slot    <= 1'b0;
                sda_r   <= 1'b1;
                start_r <= 1'b1;
            end else if (stop_c) begin
                state  <= IDLE;
                slot   <= 1'b0;
                sda_r  <= 1'b1;
                busy_r <= 1'b0;
                stop_r <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shreg <= {shreg[6:0], sda_s};
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            if (shreg[6:0] == SLAVE_ADDR) begin
                                busy_r <= 1'b1;
                                rw     <= sda_s;
                                slot   <= 1'b0;
                                state  <= ADDR_ACK;
                            end else begin
                                busy_r <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!slot) begin
                            sda_r <= 1'b0;
                            slot  <= 1'b1;
                        end else begin
                            slot <= 1'b0;
                            cnt  <= 3'd7;
                            if (rw) begin
                                state <= READ;
                            end else begin
                                sda_r <= 1'b1;
                                first <= 1'b1;
                                state <= WRITE;
                            end
                        end
                    end
                    WRITE: if (scl_rise) begin
                        shreg <= {shreg[6:0], sda_s};
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            rx_data_r  <= {shreg[6:0], sda_s};
                            rx_valid_r <= 1'b1;
                            rx_first_r <= first;
                            first      <= 1'b0;
                            slot       <= 1'b0;
                            state      <= WRITE_ACK;
                        end
                    end
                    WRITE_ACK: if (scl_fall) begin
                        if (!slot) begin
                            sda_r <= 1'b0;
                            slot  <= 1'b1;
                        end else begin
                            sda_r <= 1'b1;
                            slot  <= 1'b0;
                            cnt   <= 3'd7;
                            state <= WRITE;
                        end
                    end
                    READ: if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            sda_r <= 1'b1;
                            slot  <= 1'b0;
                            state <= READ_ACK;
                        end else begin
                            sda_r <= shreg[6];
                            shreg <= {shreg[6:0], 1'b0};
                            cnt   <= cnt - 3'd1;
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                nack_r <= 1'b1;
                                busy_r <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                slot <= 1'b1;
                            end
                        end else if (scl_fall && slot) begin
                            slot  <= 1'b0;
                            cnt   <= 3'd7;
                            state <= READ;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (load_now) begin
                    shreg   <= next_byte;
                    sda_r   <= next_byte[7];
                    uflow_r <= ~hold_full;
                end
            end
        end
    end
endmodule
